gray_seq_ctrl: RTL

Sequencer that owns a binary counter and drives it through the binary-to-Gray conversion, emitting one {binary, Gray} word per handshake over a programmable range.
Used wherever the design needs a streamed Gray-code sweep, such as pointer generation, encoder test patterns or converter self-check.
Supports up/down direction, modulo-2^WIDTH wrap-around, valid/ready backpressure and abort.
Gray conversion is computed internally as bin ^ (bin >> 1) and registered together with the binary value.

---
 rtl/gray_seq_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/gray_seq_ctrl.sv
// Streams {binary, Gray} words over a programmable up/down range, one per handshake; first word 1 cycle after start.
// Backpressure: words hold stable while out_valid && !out_ready; abort drops the pending word without a done pulse.
module gray_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] start_value,
    input  logic [WIDTH-1:0] end_value,
    input  logic             dir,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] end_q;
    logic             dir_q;
    logic [WIDTH-1:0] bin_step;
    logic             xfer;
    logic             at_end;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign at_end   = (bin_q == end_q);
    // abort wins over a coincident handshake, so such a word is never counted as moved
    assign xfer     = (state == RUN) && out_ready && !abort;
    assign bin_step = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer && at_end) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            end_q  <= '0;
            dir_q  <= 1'b0;
        end else if (state == IDLE && start) begin
            bin_q  <= start_value;
            gray_q <= to_gray(start_value);
            end_q  <= end_value;
            dir_q  <= dir;
        end else if (xfer && !at_end) begin
            bin_q  <= bin_step;
            gray_q <= to_gray(bin_step);
        end
    end

    assign out_valid = (state == RUN);
    assign bin_out   = bin_q;
    assign gray_out  = gray_q;
    assign last      = out_valid && at_end;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
